// File: rtl/project_pkg.sv
// Shared types for the project CPU control path: instruction set, ALU operations,
// register address type and controller state encoding.
package project_pkg;

  localparam int REG_ADDR_W = 2;

  typedef logic [REG_ADDR_W-1:0] regAddr;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    ADDI = 4'h2,
    SUB  = 4'h3,
    AND  = 4'h4,
    OR   = 4'h5,
    NOT  = 4'h6,
    LW   = 4'h7,
    SW   = 4'h8,
    COPY = 4'h9,
    RO   = 4'hA,
    WO   = 4'hB,
    JEQ  = 4'hC,
    ZERO = 4'hD
  } e_instr;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_NOT = 3'd5
  } e_alu_op;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    IMM    = 3'd3,
    EXEC   = 3'd4,
    MEM    = 3'd5,
    TRAP   = 3'd6
  } e_ctrl_state;

  // Opcodes past ZERO are unassigned encodings.
  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'(ZERO);
  endfunction

  // Instructions that write the register file from the ALU in EXEC.
  function automatic logic op_writes_reg(input e_instr op);
    logic wr;
    case (op)
      ADD, ADDI, SUB, AND, OR, NOT, COPY, RO: wr = 1'b1;
      default:                                wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into opcode and register fields
// and selects the ALU operation for the instruction.
module instr_decode
  import project_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 4,
  parameter int RA_W   = 2
) (
  input  logic [WORD_W-1:0] ir,
  output e_instr            instr_op,
  output logic [RA_W-1:0]   rs,
  output logic [RA_W-1:0]   rt,
  output e_alu_op           alu_op,
  output logic              is_legal
);

  logic [OP_W-1:0] op_field;

  always_comb begin
    op_field = ir[WORD_W-1 -: OP_W];
    instr_op = e_instr'(op_field);
    rs       = ir[2*RA_W-1:RA_W];
    rt       = ir[RA_W-1:0];
    is_legal = op_is_legal(op_field);
    alu_op   = ALU_NOP;
    case (instr_op)
      ADD, ADDI: alu_op = ALU_ADD;
      SUB, JEQ:  alu_op = ALU_SUB;
      AND:       alu_op = ALU_AND;
      OR:        alu_op = ALU_OR;
      NOT:       alu_op = ALU_NOT;
      default:   alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control unit: FETCH/DECODE/IMM/EXEC/MEM sequencing over a req/ack memory.
// Define MCTRL_TRAP_EN to add the trap output and lock up on undefined opcodes.
module multicycle_controller
  import project_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 4,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              zero,
  output logic              mem_req,
  output logic              mem_wr,
  output logic              addr_sel,
  output logic              ir_wr,
  output logic              imm_wr,
  output logic              pc_inc,
  output logic              pc_load,
  output e_alu_op           alu_op,
  output logic              alu_src,
  output logic              reg_wr,
  output logic              mem_to_reg,
  output e_instr            instr_op,
  output logic [RA_W-1:0]   rs,
  output logic [RA_W-1:0]   rt,
  output logic              busy
`ifdef MCTRL_TRAP_EN
  ,
  output logic              trap
`endif
);

`ifdef MCTRL_TRAP_EN
  localparam e_ctrl_state ILLEGAL_NEXT = TRAP;
`else
  localparam e_ctrl_state ILLEGAL_NEXT = FETCH;
`endif

  e_ctrl_state       state;
  logic [WORD_W-1:0] ir;
  e_alu_op           dec_alu_op;
  logic              dec_legal;

  instr_decode #(
    .WORD_W(WORD_W),
    .OP_W  (OP_W),
    .RA_W  (RA_W)
  ) u_decode (
    .ir      (ir),
    .instr_op(instr_op),
    .rs      (rs),
    .rt      (rt),
    .alu_op  (dec_alu_op),
    .is_legal(dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_legal) begin
            state <= ILLEGAL_NEXT;
          end else begin
            case (instr_op)
              ADDI:      state <= IMM;
              LW, SW:    state <= MEM;
              NOP, ZERO: state <= FETCH;
              default:   state <= EXEC;
            endcase
          end
        end
        IMM:   if (mem_ack) state <= EXEC;
        EXEC:  state <= FETCH;
        MEM:   if (mem_ack) state <= FETCH;
        TRAP:  state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so an async reset removes mem_req at once;
  // ack-qualified strobes fire in the completing cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_wr      = 1'b0;
    imm_wr     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_op     = ALU_NOP;
    alu_src    = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr  = 1'b1;
          pc_inc = 1'b1;
        end
      end
      IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_wr = 1'b1;
          pc_inc = 1'b1;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_wr   = (instr_op == SW);
        if (mem_ack && instr_op == LW) begin
          reg_wr     = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = (instr_op == ADDI);
        reg_wr  = op_writes_reg(instr_op);
        pc_load = (instr_op == JEQ) && zero;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef MCTRL_TRAP_EN
  assign trap = (state == TRAP);
`endif

endmodule
